// File: rtl/serial_adder_nbit_pkg.sv
// Shared definitions for bit-serial arithmetic blocks:
// FSM state encoding and operand-width legality helpers.
package serial_adder_nbit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 64;

    function automatic bit width_legal(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_nbit_full_adder_cell.sv
// Combinational 1-bit full adder; the only arithmetic
// element of the serial adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_nbit.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first,
// valid/ready on both the operand and result sides.
module serial_adder_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);

    import serial_adder_nbit_pkg::*;

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    generate
        if (!width_legal(WIDTH)) begin : g_bad_width
            $error("serial_adder_nbit: WIDTH must be 1..64");
        end
    endgenerate

    sa_state_t state;
    sa_state_t state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last;

    full_adder_cell u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (carry),
        .sum  (fa_s),
        .cout (fa_co)
    );

    // Sum bits enter from the MSB so the word is aligned after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_sr1
            assign sr_nxt = fa_s;
        end else begin : g_srn
            assign sr_nxt = {fa_s, sr[WIDTH-1:1]};
        end
    endgenerate

    assign IN_READY  = (state == IDLE);
    assign OUT_VALID = (state == DONE);
    assign accept    = IN_READY && IN_VALID;
    assign last      = (state == RUN) && (cnt == LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (IN_VALID)     state_nxt = RUN;
            RUN:     if (cnt == LAST)  state_nxt = DONE;
            DONE:    if (OUT_READY)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            SUM   <= '0;
            COUT  <= 1'b0;
            OVF   <= 1'b0;
        end else if (accept) begin
            sa    <= A;
            sb    <= SUB ? ~B : B;
            carry <= SUB | CIN;
            cnt   <= '0;
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            sr    <= sr_nxt;
            carry <= fa_co;
            if (last) begin
                // carry still holds the carry into the MSB here
                SUM  <= sr_nxt;
                COUT <= fa_co;
                OVF  <= carry ^ fa_co;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Randomised and directed bench for serial_adder_nbit
// (WIDTH=8 and WIDTH=1) against an arithmetic reference.
module tb_serial_adder_nbit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       iv8 = 1'b0, or8 = 1'b0, ci8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ir8, ov8, co8, of8;
    logic [7:0] s8;

    logic       iv1 = 1'b0, or1 = 1'b0, ci1 = 1'b0, sub1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       ir1, ov1, co1, of1;
    logic [0:0] s1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_adder_nbit #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst), .IN_VALID(iv8), .IN_READY(ir8),
        .A(a8), .B(b8), .CIN(ci8), .SUB(sub8),
        .OUT_VALID(ov8), .OUT_READY(or8),
        .SUM(s8), .COUT(co8), .OVF(of8)
    );

    serial_adder_nbit #(.WIDTH(1)) dut1 (
        .CLK(clk), .RST(rst), .IN_VALID(iv1), .IN_READY(ir1),
        .A(a1), .B(b1), .CIN(ci1), .SUB(sub1),
        .OUT_VALID(ov1), .OUT_READY(or1),
        .SUM(s1), .COUT(co1), .OVF(of1)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: two's-complement arithmetic on plain integers.
    function automatic void ref_op(input int w, input longint a,
                                   input longint b, input bit ci,
                                   input bit sub, output longint sum,
                                   output bit cout, output bit ovf);
        longint m, half, sa, sb, r;
        m    = longint'(1) << w;
        half = m / 2;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        if (sub) begin
            sum  = (((a - b) % m) + m) % m;
            cout = (a >= b);
            r    = sa - sb;
        end else begin
            sum  = (a + b + longint'(ci)) % m;
            cout = (a + b + longint'(ci)) >= m;
            r    = sa + sb + longint'(ci);
        end
        ovf = (r >= half) || (r < -half);
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input bit ci, input bit sub, input int hold);
        longint es;
        bit     ec, eo;
        int     n;
        ref_op(8, longint'(a), longint'(b), ci, sub, es, ec, eo);
        chk("ir_idle", 64'(ir8), 64'(1));
        a8 = a; b8 = b; ci8 = ci; sub8 = sub; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        n = 0;
        while (!ov8 && n < 20) begin
            chk("ir_run", 64'(ir8), 64'(0));
            @(posedge clk); #1;
            n++;
            iv8 = (n == 3);
        end
        iv8 = 1'b0;
        chk("latency8", 64'(n), 64'(8));
        chk("sum8", 64'(s8), 64'(es));
        chk("cout8", 64'(co8), 64'(ec));
        chk("ovf8", 64'(of8), 64'(eo));
        for (int i = 0; i < hold; i++) begin
            iv8 = 1'b1;
            @(posedge clk); #1;
            chk("hold_ov", 64'(ov8), 64'(1));
            chk("hold_ir", 64'(ir8), 64'(0));
            chk("hold_sum", 64'(s8), 64'(es));
            chk("hold_cf", 64'({co8, of8}), 64'({ec, eo}));
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        chk("ov_clear", 64'(ov8), 64'(0));
        chk("ir_back", 64'(ir8), 64'(1));
    endtask

    initial begin
        longint es;
        bit     ec, eo;
        int     n;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ir8", 64'(ir8), 64'(1));
        chk("rst_ov8", 64'(ov8), 64'(0));
        chk("rst_out8", 64'({s8, co8, of8}), 64'(0));
        chk("rst_ir1", 64'(ir1), 64'(1));
        chk("rst_out1", 64'({ov1, s1, co1, of1}), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        run8(8'h0F, 8'h01, 1'b0, 1'b0, 0);
        run8(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run8(8'h7F, 8'h01, 1'b0, 1'b0, 0);
        run8(8'hFF, 8'h00, 1'b1, 1'b0, 0);
        run8(8'h05, 8'h07, 1'b1, 1'b1, 0);
        run8(8'h80, 8'h01, 1'b0, 1'b1, 5);

        // abort mid-RUN with an asynchronous reset
        a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b1; sub8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_ir", 64'(ir8), 64'(0));
        rst = 1'b1;
        #1;
        chk("arst_ir", 64'(ir8), 64'(1));
        chk("arst_ov", 64'(ov8), 64'(0));
        chk("arst_out", 64'({s8, co8, of8}), 64'(0));
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run8(8'h12, 8'h34, 1'b0, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom),
                 1'($urandom), $urandom_range(0, 3));
        end

        for (int i = 0; i < 16; i++) begin
            a1 = 1'(i); b1 = 1'(i >> 1); ci1 = 1'(i >> 2); sub1 = 1'(i >> 3);
            ref_op(1, longint'(a1), longint'(b1), ci1, sub1, es, ec, eo);
            chk("ir1_idle", 64'(ir1), 64'(1));
            iv1 = 1'b1;
            @(posedge clk); #1;
            iv1 = 1'b0;
            n = 0;
            while (!ov1 && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            chk("latency1", 64'(n), 64'(1));
            chk("sum1", 64'(s1), 64'(es));
            chk("cout1", 64'(co1), 64'(ec));
            chk("ovf1", 64'(of1), 64'(eo));
            or1 = 1'b1;
            @(posedge clk); #1;
            or1 = 1'b0;
            chk("ov1_clear", 64'(ov1), 64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder_nbit.md
# serial_adder_nbit

Parametrised bit-serial adder/subtractor built around a single 1-bit full-adder cell and a carry flip-flop. Accepts two WIDTH-bit operands through a valid/ready handshake and processes one bit per clock, LSB first. Presents SUM, COUT and a signed-overflow flag after WIDTH cycles, holding them until the consumer accepts. This is the multi-bit, sequential successor to the combinational 1-bit full adder, for area-constrained datapaths.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  operands and mode present on A, B, CIN, SUB.
- IN_READY  output  1  block can accept an operation; high only in IDLE.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CIN  input  1  carry-in for add; ignored when SUB=1.
- SUB  input  1  0: A+B+CIN; 1: A-B, computed as A+~B+1.
- OUT_VALID  output  1  result valid; high only in DONE.
- OUT_READY  input  1  consumer accepts result.
- SUM  output  WIDTH  result bits.
- COUT  output  1  carry out of MSB; in SUB mode, 1 means no borrow.
- OVF  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation

- States: IDLE, RUN, DONE.
- IDLE: IN_READY=1. On IN_VALID: latch A into shift register SA, latch B (or ~B if SUB) into SB, set carry to (SUB ? 1 : CIN), clear bit counter, go to RUN.
- RUN: each cycle, the cell adds SA[0], SB[0] and carry. The sum bit shifts into SUM from the MSB side; SA and SB shift right; carry updates. The counter increments. When counter == WIDTH-1, capture carry-in of that bit as MSB carry, write final carry to COUT and OVF, and go to DONE.
- DONE: OUT_VALID=1; SUM, COUT and OVF stable. On OUT_READY, go to IDLE. Without OUT_READY, hold indefinitely.
- IN_VALID outside IDLE is ignored; no operation is queued.
- SUM, COUT and OVF keep their last values in IDLE and RUN. Consumers use them only while OUT_VALID=1.
- Arithmetic is modulo 2^WIDTH; the carry is the only extra state.
- WIDTH=1: RUN lasts exactly one cycle; OVF = carry-in XOR COUT of that single bit.

## Timing

- Reset (asynchronous, any state, including mid-RUN): state=IDLE, IN_READY=1, OUT_VALID=0, SUM=0, COUT=0, OVF=0, counter=0, carry=0. The in-flight operation is discarded.
- Accept on edge k (IN_VALID & IN_READY). RUN covers edges k+1..k+WIDTH. OUT_VALID rises after edge k+WIDTH, a latency of WIDTH cycles.
- Result handshake on edge m (OUT_VALID & OUT_READY) returns to IDLE. The next accept is possible at edge m+1 at the earliest.
- Maximum throughput: one operation per WIDTH+2 cycles.
- Counter width: max(1, clog2(WIDTH)) bits; never wraps within an operation.

## Structure

- Shared package/include: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH legality check, for reuse by future serial arithmetic blocks.
- One sub-module: full_adder_cell (combinational 1-bit A, B, CIN -> SUM, COUT), instantiated once.
- Top level holds the FSM, counter, shift registers, carry flop and output registers.

## Test plan

All cases use WIDTH=8 unless stated.

- A=0x0F, B=0x01, CIN=0, SUB=0 -> SUM=0x10, COUT=0, OVF=0; OUT_VALID exactly 8 cycles after accept.
- A=0xFF, B=0x01, CIN=0 -> SUM=0x00, COUT=1, OVF=0. A=0x7F, B=0x01 -> SUM=0x80, COUT=0, OVF=1. A=0xFF, B=0x00, CIN=1 -> SUM=0x00, COUT=1.
- SUB=1, A=0x05, B=0x07, CIN=1 (ignored) -> SUM=0xFE, COUT=0, OVF=0. SUB=1, A=0x80, B=0x01 -> SUM=0x7F, COUT=1, OVF=1.
- Backpressure: hold OUT_READY=0 for 5 cycles in DONE -> OUT_VALID stays 1, SUM/COUT/OVF unchanged, IN_READY=0; IN_VALID pulses during RUN/DONE are ignored.
- Assert RST 3 cycles into RUN -> all outputs 0 and IN_READY=1 immediately. A subsequent A=0x12, B=0x34 -> SUM=0x46.
- WIDTH=1 instance: all 8 combinations of A, B, CIN -> full-adder truth table. OUT_VALID 1 cycle after accept.
